// File: rtl/uart_pkg.sv
// Shared UART-path definitions: byte/word widths, FSM states and the default
// inter-byte timeout, so serializer and assembler agree on layout and ordering.
package uart_pkg;

  localparam int BYTE_W                 = 8;
  localparam int WORD_W                 = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT_LO = 2'b01
  } state_e;

  // Width needed to hold 0..cycles, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// Saturating inter-byte counter; flags the terminal-count cycle while counting.
module byte_timeout_counter
  import uart_pkg::*;
#(
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int CNT_W          = cnt_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] TERM = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero timeout disables expiry entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt_q == TERM);

endmodule

// File: rtl/data_assembler.sv
// Packs pairs of received bytes into 16-bit words (first byte high) and drops
// a stranded first byte after an inter-byte timeout or on flush.
module data_assembler
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_enable,
  input  logic              i_flush,
  output logic [WORD_W-1:0] o_data,
  output logic              o_enable,
  output logic              o_busy,
  output logic              o_timeout
);

  state_e            state_d, state_q;
  logic [BYTE_W-1:0] hi_reg_d, hi_reg_q;
  logic [WORD_W-1:0] data_d, data_q;
  logic              enable_d, enable_q;
  logic              busy_d, busy_q;
  logic              timeout_d, timeout_q;
  logic              cnt_clear, cnt_enable, cnt_expired;

  assign cnt_clear  = !i_flush && (state_q == IDLE) && i_enable;
  assign cnt_enable = (state_q == WAIT_LO) && !i_enable;

  byte_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .expired(cnt_expired)
  );

  always_comb begin
    state_d   = state_q;
    hi_reg_d  = hi_reg_q;
    data_d    = data_q;
    enable_d  = 1'b0;
    timeout_d = 1'b0;
    // Flush wins over both a strobe and an expiring timeout.
    if (i_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_enable) begin
            hi_reg_d = i_data;
            state_d  = WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (i_enable) begin
            data_d   = {hi_reg_q, i_data};
            enable_d = 1'b1;
            state_d  = IDLE;
          end else if (cnt_expired) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == WAIT_LO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      hi_reg_q  <= '0;
      data_q    <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_reg_q  <= hi_reg_d;
      data_q    <= data_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_data    = data_q;
  assign o_enable  = enable_q;
  assign o_busy    = busy_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_data_assembler.sv
// Scoreboard bench for data_assembler: a cycle-indexed byte-pairing model
// predicts words, timeouts, busy and held data; a monitor checks each edge.
module tb_data_assembler;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  i_data = 8'h00;
  logic        i_enable = 1'b0;
  logic        i_flush = 1'b0;
  logic [15:0] o_data;
  logic        o_enable;
  logic        o_busy;
  logic        o_timeout;

  data_assembler #(.TIMEOUT_CYCLES(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_data   (i_data),
    .i_enable (i_enable),
    .i_flush  (i_flush),
    .o_data   (o_data),
    .o_enable (o_enable),
    .o_busy   (o_busy),
    .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_word;
    logic [15:0] word;
    int          idx;
  } ev_t;

  typedef struct {
    bit          busy;
    logic [15:0] data;
  } cy_t;

  ev_t evq[$];
  cy_t cyq[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: a pending first byte and the edge index it arrived on.
  bit          m_pend = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  int          m_start = 0;
  int          m_idx = 0;
  logic [15:0] m_last = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit en, input logic [7:0] d, input bit fl);
    ev_t e;
    cy_t c;
    @(negedge clk);
    reset    = ~rst;
    i_enable = en;
    i_data   = d;
    i_flush  = fl;
    m_idx++;
    if (rst) begin
      m_pend = 1'b0;
      m_last = 16'h0000;
    end else if (fl) begin
      m_pend = 1'b0;
    end else if (en) begin
      if (m_pend) begin
        m_last    = {m_hi, d};
        e.is_word = 1'b1;
        e.word    = m_last;
        e.idx     = m_idx;
        evq.push_back(e);
        m_pend = 1'b0;
      end else begin
        m_pend  = 1'b1;
        m_hi    = d;
        m_start = m_idx;
      end
    end else if (m_pend && (m_idx - m_start == T)) begin
      e.is_word = 1'b0;
      e.word    = m_last;
      e.idx     = m_idx;
      evq.push_back(e);
      m_pend = 1'b0;
    end
    c.busy = m_pend;
    c.data = m_last;
    cyq.push_back(c);
    if (rst) begin
      #1;
      chk("async_rst_data", o_data, 0);
      chk("async_rst_busy", o_busy, 0);
      chk("async_rst_pulses", {o_enable, o_timeout}, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic strobe(input logic [7:0] d);
    drive(1'b0, 1'b1, d, 1'b0);
  endtask

  // Monitor: one per-cycle entry per edge, plus event entries on pulses.
  int  pop_idx = 0;
  cy_t mc;
  ev_t me;

  always @(posedge clk) begin
    #1;
    if (cyq.size() > 0) begin
      mc = cyq.pop_front();
      pop_idx++;
      chk("busy", o_busy, mc.busy);
      chk("held_data", o_data, mc.data);
      if (o_enable || o_timeout) begin
        if (o_enable && o_timeout) begin
          checks++;
          errors++;
          $display("FAIL both_pulses: o_enable=1 o_timeout=1 at edge %0d", pop_idx);
        end
        if (evq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: o_enable=%0b o_timeout=%0b at edge %0d, none expected",
                   o_enable, o_timeout, pop_idx);
        end else begin
          me = evq.pop_front();
          chk("event_kind_enable", o_enable, me.is_word);
          chk("event_edge", pop_idx, me.idx);
          if (me.is_word) chk("word", o_data, me.word);
        end
      end else if (evq.size() > 0 && evq[0].idx <= pop_idx) begin
        me = evq.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event: no pulse at edge %0d, expected %s %h",
                 pop_idx, me.is_word ? "word" : "timeout", me.word);
      end
    end
  end

  initial begin
    logic [7:0] rd;
    int         r;
    int         g;
    // Reset held for a few cycles.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    idle(2);

    // Basic pair with a gap.
    strobe(8'hA5); idle(2); strobe(8'h3C); idle(3);
    // Back-to-back stream.
    strobe(8'h12); strobe(8'h34); strobe(8'h56); strobe(8'h78); idle(3);
    // Timeout then clean pair.
    strobe(8'hFF); idle(T + 4); strobe(8'h01); strobe(8'h02); idle(2);
    // Second byte exactly on terminal count.
    strobe(8'h44); idle(T - 1); strobe(8'h77); idle(3);
    // One cycle too late: timeout, then the late byte becomes a new high byte.
    strobe(8'h55); idle(T); strobe(8'h66); strobe(8'h99); idle(2);
    // Flush with simultaneous strobe.
    strobe(8'hAA); drive(1'b0, 1'b1, 8'hBB, 1'b1); idle(2);
    strobe(8'h11); strobe(8'h22); idle(2);
    // Reset mid-word.
    strobe(8'hC0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h5A, 1'b0);
    strobe(8'hDD); strobe(8'hEE); idle(3);

    // Randomized traffic with idle gaps, flushes and occasional resets.
    for (int i = 0; i < 800; i++) begin
      r  = $urandom_range(0, 99);
      rd = 8'($urandom);
      if (r < 4) begin
        g = $urandom_range(T - 2, T + 3);
        idle(g);
      end else if (r == 4) begin
        drive(1'b1, $urandom_range(0, 1) == 1, rd, 1'b0);
      end else begin
        drive(1'b0, r < 55, rd, r >= 96);
      end
    end
    idle(T + 4);

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("events_drained", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
